// File: rtl/wide_add_pkg.sv
// Shared definitions for the word-serial wide adder: FSM encoding and counter sizing.
package wide_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Minimum bit count able to index n words; never returns less than 1.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/carry_select_adder.sv
// WIDTH-bit carry-select adder: each BLOCK_WIDTH slice precomputes both carry-in cases.
module carry_select_adder #(
  parameter int WIDTH       = 16,
  parameter int BLOCK_WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o
);

  localparam int NB = WIDTH / BLOCK_WIDTH;

  logic [NB:0] cy;

  assign cy[0] = c_i;

  for (genvar g = 0; g < NB; g++) begin : g_blk
    logic [BLOCK_WIDTH:0] sum0;
    logic [BLOCK_WIDTH:0] sum1;

    assign sum0 = {1'b0, a_i[g*BLOCK_WIDTH +: BLOCK_WIDTH]}
                + {1'b0, b_i[g*BLOCK_WIDTH +: BLOCK_WIDTH]};
    assign sum1 = {1'b0, a_i[g*BLOCK_WIDTH +: BLOCK_WIDTH]}
                + {1'b0, b_i[g*BLOCK_WIDTH +: BLOCK_WIDTH]}
                + (BLOCK_WIDTH+1)'(1);

    assign s_o[g*BLOCK_WIDTH +: BLOCK_WIDTH] = cy[g] ? sum1[BLOCK_WIDTH-1:0] : sum0[BLOCK_WIDTH-1:0];
    assign cy[g+1] = cy[g] ? sum1[BLOCK_WIDTH] : sum0[BLOCK_WIDTH];
  end

  assign c_o = cy[NB];

endmodule

// File: rtl/wide_add_sequencer.sv
// Adds/subtracts WIDTH*WORDS-bit operands one word per cycle through a single shared adder.
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int BLOCK_WIDTH = 4,
  parameter int WORDS       = 4
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   iStart,
  input  logic                   iSub,
  input  logic [WIDTH*WORDS-1:0] iA,
  input  logic [WIDTH*WORDS-1:0] iB,
  input  logic                   iC,
  output logic                   oReady,
  output logic                   oDone,
  output logic [WIDTH*WORDS-1:0] oS,
  output logic                   oC,
  output logic                   oV,
  output logic [1:0]             oState
);

  localparam int TW = WIDTH * WORDS;
  localparam int KW = clog2(WORDS);
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  state_e          state_q, state_d;
  logic [TW-1:0]   a_q, b_q, s_q;
  logic [KW-1:0]   k_q;
  logic            carry_q, c_q, v_q;
  logic [WIDTH-1:0] word_a, word_b, word_s;
  logic            word_c, accept, running, last_word;

  assign accept    = (state_q == IDLE) && iStart;
  assign running   = (state_q == RUN);
  assign last_word = running && (k_q == K_LAST);

  assign word_a = a_q[k_q*WIDTH +: WIDTH];
  assign word_b = b_q[k_q*WIDTH +: WIDTH];

  carry_select_adder #(
    .WIDTH       (WIDTH),
    .BLOCK_WIDTH (BLOCK_WIDTH)
  ) u_adder (
    .a_i (word_a),
    .b_i (word_b),
    .c_i (carry_q),
    .s_o (word_s),
    .c_o (word_c)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (iStart) state_d = RUN;
      RUN:     if (k_q == K_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    oReady = (state_q == IDLE);
    oDone  = (state_q == DONE);
  end

  // Subtraction is A + ~B + (1 - borrow_in), so B is stored pre-inverted.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else if (accept) begin
      a_q     <= iA;
      b_q     <= iSub ? ~iB : iB;
      carry_q <= iC ^ iSub;
      k_q     <= '0;
    end else if (running) begin
      s_q[k_q*WIDTH +: WIDTH] <= word_s;
      carry_q <= word_c;
      k_q     <= k_q + 1'b1;
      if (last_word) begin
        c_q <= word_c;
        v_q <= (word_a[WIDTH-1] == word_b[WIDTH-1]) && (word_s[WIDTH-1] != word_a[WIDTH-1]);
      end
    end
  end

  assign oS     = s_q;
  assign oC     = c_q;
  assign oV     = v_q;
  assign oState = state_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed and random checks of wide_add_sequencer at default parameters (16-bit words x 4).
module tb_wide_add_sequencer;

  localparam int W = 64;

  logic         iClk, iRst, iStart, iSub, iC;
  logic [W-1:0] iA, iB;
  logic         oReady, oDone, oC, oV;
  logic [W-1:0] oS;
  logic [1:0]   oState;

  int n_cmp = 0;
  int n_err = 0;

  wide_add_sequencer dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iStart (iStart),
    .iSub   (iSub),
    .iA     (iA),
    .iB     (iB),
    .iC     (iC),
    .oReady (oReady),
    .oDone  (oDone),
    .oS     (oS),
    .oC     (oC),
    .oV     (oV),
    .oState (oState)
  );

  // clock / reset
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver: waits for ready, issues one op, returns result at oDone
  task automatic do_op(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, output logic [W-1:0] s, output logic co,
                       output logic vo, output int cycles);
    int guard;
    guard = 0;
    @(negedge iClk);
    while (!oReady && guard < 20) begin
      @(negedge iClk);
      guard++;
    end
    iSub = sub; iA = a; iB = b; iC = c; iStart = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
    cycles = 1;
    while (!oDone && cycles < 20) begin
      @(posedge iClk); #1;
      cycles++;
    end
    if (!oDone) check_eq("done_timeout", 64'(oDone), 64'd1);
    s = oS; co = oC; vo = oV;
  endtask

  typedef struct {
    string        tag;
    logic         sub;
    logic [W-1:0] a, b;
    logic         c;
    logic [W-1:0] s;
    logic         co, vo;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [W-1:0] s, exp_s, beff;
    logic         co, vo, rc, rsub;
    logic [W:0]   full;
    logic [W-1:0] ra, rb;
    int           cycles, pulses, guard;

    vecs[0] = '{"add_wrap",   1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0};
    vecs[1] = '{"sub_borrow", 1'b1, 64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[2] = '{"add_ovf",    1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[3] = '{"sub_simple", 1'b1, 64'd5, 64'd3, 1'b0, 64'd2, 1'b1, 1'b0};
    vecs[4] = '{"sub_bin",    1'b1, 64'd10, 64'd3, 1'b1, 64'd6, 1'b1, 1'b0};
    vecs[5] = '{"add_cin",    1'b0, 64'h0000_0000_0000_FFFF, 64'd1, 1'b1, 64'h0000_0000_0001_0001, 1'b0, 1'b0};
    vecs[6] = '{"sub_ovf",    1'b1, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};

    iRst = 1'b1; iStart = 1'b0; iSub = 1'b0; iA = '0; iB = '0; iC = 1'b0;
    #1;
    check_eq("rst_state", 64'(oState), 64'd0);
    check_eq("rst_ready", 64'(oReady), 64'd1);
    check_eq("rst_done",  64'(oDone),  64'd0);
    check_eq("rst_s",     oS,          64'd0);
    check_eq("rst_c",     64'(oC),     64'd0);
    check_eq("rst_v",     64'(oV),     64'd0);
    repeat (2) @(negedge iClk);
    iRst = 1'b0;

    foreach (vecs[i]) begin
      do_op(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].c, s, co, vo, cycles);
      check_eq({vecs[i].tag, "_s"}, s, vecs[i].s);
      check_eq({vecs[i].tag, "_c"}, 64'(co), 64'(vecs[i].co));
      check_eq({vecs[i].tag, "_v"}, 64'(vo), 64'(vecs[i].vo));
      if (i == 0) check_eq("latency", 64'(cycles), 64'd5);
    end

    // results hold after the done cycle
    repeat (3) @(posedge iClk);
    #1;
    check_eq("hold_s", oS, 64'h7FFF_FFFF_FFFF_FFFF);
    check_eq("hold_c", 64'(oC), 64'd1);
    check_eq("hold_v", 64'(oV), 64'd1);

    // busy start: second request during RUN is ignored
    @(negedge iClk);
    iSub = 1'b0; iA = 64'h1234_5678_9ABC_DEF0; iB = 64'h1111_1111_1111_1111; iC = 1'b0; iStart = 1'b1;
    @(posedge iClk); #1;
    check_eq("busy_accept", 64'(oReady), 64'd0);
    @(negedge iClk);
    iSub = 1'b1; iA = 64'hFFFF_FFFF_FFFF_FFFF; iB = 64'hFFFF_FFFF_FFFF_FFFF; iC = 1'b1;
    pulses = 0;
    exp_s = '0;
    for (int t = 0; t < 10; t++) begin
      @(posedge iClk); #1;
      if (t == 2) iStart = 1'b0;
      if (oDone) begin
        pulses++;
        exp_s = oS;
      end
    end
    check_eq("busy_s", exp_s, 64'h2345_6789_ABCD_F001);
    check_eq("busy_pulses", 64'(pulses), 64'd1);

    // reset mid-RUN at k=2
    @(negedge iClk);
    iSub = 1'b0; iA = 64'hAAAA_AAAA_AAAA_AAAA; iB = 64'h5555_5555_5555_5555; iC = 1'b0; iStart = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
    repeat (2) @(posedge iClk);
    #2;
    iRst = 1'b1;
    #1;
    check_eq("mid_rst_s",     oS,          64'd0);
    check_eq("mid_rst_c",     64'(oC),     64'd0);
    check_eq("mid_rst_v",     64'(oV),     64'd0);
    check_eq("mid_rst_done",  64'(oDone),  64'd0);
    check_eq("mid_rst_ready", 64'(oReady), 64'd1);
    @(negedge iClk);
    iRst = 1'b0; iSub = 1'b0; iA = 64'd1; iB = 64'd2; iC = 1'b1; iStart = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
    check_eq("post_rst_accept", 64'(oState), 64'd1);
    guard = 0;
    while (!oDone && guard < 20) begin
      @(posedge iClk); #1;
      guard++;
    end
    check_eq("post_rst_done", 64'(oDone), 64'd1);
    check_eq("post_rst_s", oS, 64'd4);

    // random ops against a 65-bit reference
    for (int n = 0; n < 1000; n++) begin
      ra   = {$urandom(), $urandom()};
      rb   = {$urandom(), $urandom()};
      rsub = 1'($urandom_range(0, 1));
      rc   = 1'($urandom_range(0, 1));
      if (n % 16 == 0) rb = 64'hFFFF_FFFF_FFFF_FFFF;
      beff = rsub ? ~rb : rb;
      full = {1'b0, ra} + {1'b0, beff} + 65'(rc ^ rsub);
      do_op(rsub, ra, rb, rc, s, co, vo, cycles);
      check_eq("rand_s", s, full[W-1:0]);
      check_eq("rand_c", 64'(co), 64'(full[W]));
      check_eq("rand_v", 64'(vo), 64'((ra[W-1] == beff[W-1]) && (full[W-1] != ra[W-1])));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wide_add_sequencer.md
WIDE_ADD_SEQUENCER -- requirements
Module: wide_add_sequencer

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the bit width of one adder word.
REQ-002 Parameter BLOCK_WIDTH, default 4, SHALL set the carry-select block width passed to the adder; WIDTH SHALL be a multiple of BLOCK_WIDTH.
REQ-003 Parameter WORDS, default 4, SHALL set the number of words per operand; WORDS SHALL be at least 2; the total operand width is WIDTH*WORDS.
REQ-004 iClk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 iRst  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 iStart  input  1  SHALL request an operation; it is sampled only while oReady=1.
REQ-007 iSub  input  1  SHALL select the operation: 0 = add, 1 = subtract.
REQ-008 iA, iB  input  WIDTH*WORDS  SHALL carry the operands, captured on an accepted start.
REQ-009 iC  input  1  SHALL carry the carry-in on add and the borrow-in on subtract.
REQ-010 oReady  output  1  SHALL be 1 only in state IDLE.
REQ-011 oDone  output  1  SHALL be a one-cycle pulse marking the result as valid.
REQ-012 oS  output  WIDTH*WORDS  SHALL carry the registered result.
REQ-013 oC  output  1  SHALL carry the registered final carry-out; on subtract, 0 means a borrow occurred.
REQ-014 oV  output  1  SHALL carry the registered two's-complement signed overflow flag.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 IDLE with iStart=1 SHALL perform all of the following in the same edge:
- capture iA into the A register;
- capture iB, or ~iB when iSub=1, into the B register;
- load the carry register with iC XOR iSub;
- clear the word counter;
- move to RUN.
REQ-017 In RUN, each cycle SHALL perform all of the following:
- add word k of A and word k of B, plus the carry register, through one shared WIDTH-bit adder;
- write the sum to oS bits [k*WIDTH +: WIDTH];
- load the carry register with the adder carry-out;
- increment k.
REQ-018 When k = WORDS-1 in RUN, the FSM SHALL move to DONE on the same edge on which the last word is written.
REQ-019 In DONE, oDone SHALL be 1 and oC SHALL equal the carry register; the FSM SHALL return to IDLE on the next edge.
REQ-020 oV SHALL be (A[msb] == Beff[msb]) && (S[msb] != A[msb]), using the top word, and SHALL be registered together with that word.
REQ-021 Latency SHALL be: start accepted at edge 0; oDone high in the cycle after edge WORDS; total WORDS+1 cycles start-to-done.
REQ-022 iStart SHALL be ignored while in RUN or DONE; operands SHALL NOT be re-captured during an operation.
REQ-023 oS, oC and oV SHALL hold their values from the DONE cycle until the next accepted start.
REQ-024 oS words not yet written in RUN SHALL retain their previous values, and SHALL NOT be treated as valid before oDone.
REQ-025 Back-to-back operation SHALL be possible with a single IDLE cycle between oDone and the next accept.
REQ-026 Arithmetic SHALL be modulo 2^(WIDTH*WORDS); oC SHALL be the carry out of bit WIDTH*WORDS-1.

Reset
REQ-027 iRst=1 SHALL immediately force the following, in any state including mid-RUN, and any operation in progress SHALL be discarded:
- state = IDLE;
- k = 0;
- carry register = 0;
- oS = 0, oC = 0, oV = 0, oDone = 0.
REQ-028 oReady SHALL be 1 from reset release onward, and the first iStart SHALL be accepted on the first edge after release.

Structure
REQ-029 Exactly one sub-module, carry_select_adder (WIDTH, BLOCK_WIDTH), SHALL be instantiated and time-shared across words.
REQ-030 A shared package wide_add_pkg SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the counter-width function clog2(WORDS).
REQ-031 Word selection SHALL be an indexed part-select on k; no per-word adders SHALL be generated.

Verification
Defaults (WIDTH=16, WORDS=4) unless stated.
REQ-032 Add: A=64'hFFFF_FFFF_FFFF_FFFF, B=1, iC=0 -> oS=0, oC=1, oV=0, oDone exactly 5 cycles after accept.
REQ-033 Subtract: A=0, B=1, iC=0 -> oS=64'hFFFF_FFFF_FFFF_FFFF, oC=0 (borrow), oV=0.
REQ-034 Signed overflow: A=64'h7FFF_FFFF_FFFF_FFFF, B=1, add -> oS=64'h8000_0000_0000_0000, oV=1, oC=0.
REQ-035 Busy start: a second iStart during RUN with different operands -> ignored; the result equals the first operation; exactly one oDone pulse.
REQ-036 Reset mid-RUN: assert iRst at k=2 -> all outputs 0 and oReady=1 immediately; a new start, 1+2 with iC=1, yields oS=4.
REQ-037 Randomized compare: at least 1000 random add/sub operations, with random iC, against a 65-bit reference model -> oS, oC and oV match on every oDone.
